// File: rtl/serial_port_router_ctrl_pkg.sv
// Shared types and constants for the serial port router controller and its bus interface.
package serial_router_pkg;

    localparam int PORT_W_DEF = 2;
    localparam int LEN_W_DEF  = 4;

    // A frame begins when the idle-high line drops to this value.
    localparam logic START_BIT = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PORT = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_port_router_ctrl_if.sv
// Bus between the frame parser (master) and the serial source / demux side (slave).
interface serial_port_router_ctrl_if
    import serial_router_pkg::*;
#(
    parameter int PORT_W = PORT_W_DEF
);
    logic              ser_in;
    logic [PORT_W-1:0] port_sel;
    logic              data_out;
    logic              data_valid;
    logic              busy;
    logic              done;

    modport master (
        input  ser_in,
        output port_sel,
        output data_out,
        output data_valid,
        output busy,
        output done
    );

    modport slave (
        output ser_in,
        input  port_sel,
        input  data_out,
        input  data_valid,
        input  busy,
        input  done
    );
endinterface

// File: rtl/serial_port_router_ctrl.sv
// Parses start/port/length/payload frames on ser_in and steers payload bits to the demux; first payload bit 1+PORT_W+LEN_W cycles after the start edge, done one cycle after the last.
// No backpressure: ser_in is consumed every cycle, outputs are valid-only with no ready.
module serial_port_router_ctrl
    import serial_router_pkg::*;
#(
    parameter int PORT_W = PORT_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_port_router_ctrl_if.master   bus
);

    localparam int CNT_W = max_w(PORT_W, LEN_W);
    localparam logic [CNT_W-1:0] PORT_LAST = CNT_W'(PORT_W - 1);
    localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            r_state;
    state_t            w_next_state;
    logic [PORT_W-1:0] r_port_sel;
    logic [PORT_W-1:0] w_port_sel_nxt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  w_len_nxt;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  w_bit_cnt_nxt;

    logic              w_ser;
    logic [LEN_W-1:0]  w_len_shift;
    logic [CNT_W-1:0]  w_len_ext;
    logic              w_data_last;
    logic              w_data_valid;

    assign w_ser        = bus.ser_in;
    assign w_len_shift  = {r_len[LEN_W-2:0], w_ser};
    assign w_len_ext    = CNT_W'(r_len);
    // Only meaningful in DATA, where the stored length is known to be non-zero.
    assign w_data_last  = (r_bit_cnt == (w_len_ext - CNT_ONE));
    assign w_data_valid = (r_state == ST_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_port_sel <= '0;
            r_len      <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_state    <= w_next_state;
            r_port_sel <= w_port_sel_nxt;
            r_len      <= w_len_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_port_sel_nxt = r_port_sel;
        w_len_nxt      = r_len;
        w_bit_cnt_nxt  = r_bit_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_ser == START_BIT) begin
                    w_next_state  = ST_PORT;
                    w_bit_cnt_nxt = '0;
                end
            end

            ST_PORT: begin
                w_port_sel_nxt = {r_port_sel[PORT_W-2:0], w_ser};
                if (r_bit_cnt == PORT_LAST) begin
                    w_next_state  = ST_LEN;
                    w_bit_cnt_nxt = '0;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CNT_ONE;
                end
            end

            ST_LEN: begin
                w_len_nxt = w_len_shift;
                if (r_bit_cnt == LEN_LAST) begin
                    // Decide on the fully assembled length, including this cycle's bit.
                    w_next_state  = (w_len_shift == '0) ? ST_DONE : ST_DATA;
                    w_bit_cnt_nxt = '0;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (w_data_last) begin
                    w_next_state  = ST_DONE;
                    w_bit_cnt_nxt = '0;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CNT_ONE;
                end
            end

            ST_DONE: begin
                w_next_state = ST_IDLE;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs decode the state register directly so reset clears them without waiting for a clock.
    assign bus.port_sel   = r_port_sel;
    assign bus.data_valid = w_data_valid;
    assign bus.data_out   = w_data_valid & w_ser;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_serial_port_router_ctrl.sv
// Directed bench for serial_port_router_ctrl: reset, idle line, normal, zero/max length, mid-frame reset, back-to-back frames.
module tb_serial_port_router_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_port_router_ctrl_if bus_if ();

    serial_port_router_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // After return: the edge just passed has sampled the previous bit, and ser_in now shows b.
    task automatic tick(input logic b);
        @(posedge clk);
        #1;
        bus_if.ser_in = b;
        #1;
    endtask

    task automatic play_frame(input string tag, input logic [1:0] port, input int len,
                              input logic [14:0] pay, input logic [1:0] prev_port);
        logic [3:0] lv;
        lv = 4'(len);
        tick(1'b0);
        chk({tag, ".start_busy"}, 8'(bus_if.busy), 8'd0);
        chk({tag, ".port_hold"}, 8'(bus_if.port_sel), 8'(prev_port));
        for (int i = 1; i >= 0; i--) begin
            tick(port[i]);
            chk({tag, ".port_busy"}, 8'(bus_if.busy), 8'd1);
            chk({tag, ".port_dv"}, 8'(bus_if.data_valid), 8'd0);
        end
        for (int i = 3; i >= 0; i--) begin
            tick(lv[i]);
            chk({tag, ".len_dv"}, 8'(bus_if.data_valid), 8'd0);
            chk({tag, ".len_done"}, 8'(bus_if.done), 8'd0);
        end
        chk({tag, ".port_sel"}, 8'(bus_if.port_sel), 8'(port));
        for (int i = 0; i < len; i++) begin
            tick(pay[i]);
            chk({tag, ".data_dv"}, 8'(bus_if.data_valid), 8'd1);
            chk({tag, ".data_out"}, 8'(bus_if.data_out), 8'(pay[i]));
            chk({tag, ".data_port"}, 8'(bus_if.port_sel), 8'(port));
            chk({tag, ".data_done"}, 8'(bus_if.done), 8'd0);
        end
        tick(1'b1);
        chk({tag, ".done"}, 8'(bus_if.done), 8'd1);
        chk({tag, ".done_dv"}, 8'(bus_if.data_valid), 8'd0);
        chk({tag, ".done_busy"}, 8'(bus_if.busy), 8'd1);
    endtask

    initial begin
        logic [9:0] fr;
        checks = 0;
        errors = 0;
        bus_if.ser_in = 1'b1;
        rst_n = 1'b0;

        // Reset state
        #2;
        chk("rst.busy", 8'(bus_if.busy), 8'd0);
        chk("rst.dv", 8'(bus_if.data_valid), 8'd0);
        chk("rst.dout", 8'(bus_if.data_out), 8'd0);
        chk("rst.done", 8'(bus_if.done), 8'd0);
        chk("rst.port", 8'(bus_if.port_sel), 8'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Idle line holds the controller in IDLE
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            chk("idle.busy", 8'(bus_if.busy), 8'd0);
            chk("idle.dv", 8'(bus_if.data_valid), 8'd0);
            chk("idle.done", 8'(bus_if.done), 8'd0);
        end

        // port=2, N=3, payload 1,0,1
        play_frame("f2n3", 2'd2, 3, 15'b101, 2'd0);
        tick(1'b1);
        chk("f2n3.after_busy", 8'(bus_if.busy), 8'd0);
        chk("f2n3.after_done", 8'(bus_if.done), 8'd0);
        chk("f2n3.after_port", 8'(bus_if.port_sel), 8'd2);

        // Zero length, port=3
        play_frame("f3n0", 2'd3, 0, 15'b0, 2'd2);
        tick(1'b1);
        chk("f3n0.after_busy", 8'(bus_if.busy), 8'd0);
        chk("f3n0.after_port", 8'(bus_if.port_sel), 8'd3);

        // Maximum length, port=1, alternating payload 1,0,1,...
        play_frame("f1n15", 2'd1, 15, 15'h5555, 2'd3);
        tick(1'b1);
        chk("f1n15.after_busy", 8'(bus_if.busy), 8'd0);

        // Back-to-back: second start bit presented in the cycle after DONE
        play_frame("b2b_a", 2'd0, 2, 15'b10, 2'd1);
        play_frame("b2b_b", 2'd3, 1, 15'b1, 2'd0);
        tick(1'b1);
        chk("b2b.after_busy", 8'(bus_if.busy), 8'd0);
        chk("b2b.after_done", 8'(bus_if.done), 8'd0);

        // Reset during the 3rd payload bit of a port=1, N=5 frame
        fr = 10'b0_01_0101_110;
        for (int i = 9; i >= 0; i--) begin
            tick(fr[i]);
            if (i <= 2) chk("mid.dv", 8'(bus_if.data_valid), 8'd1);
        end
        chk("mid.dout_bit3", 8'(bus_if.data_out), 8'd0);
        chk("mid.port_before", 8'(bus_if.port_sel), 8'd1);
        bus_if.ser_in = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid.rst_dv", 8'(bus_if.data_valid), 8'd0);
        chk("mid.rst_dout", 8'(bus_if.data_out), 8'd0);
        chk("mid.rst_busy", 8'(bus_if.busy), 8'd0);
        chk("mid.rst_done", 8'(bus_if.done), 8'd0);
        chk("mid.rst_port", 8'(bus_if.port_sel), 8'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1);
            chk("mid.post_done", 8'(bus_if.done), 8'd0);
            chk("mid.post_busy", 8'(bus_if.busy), 8'd0);
        end
        play_frame("post_rst", 2'd1, 2, 15'b01, 2'd0);
        tick(1'b1);
        chk("post_rst.after_busy", 8'(bus_if.busy), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_port_router_ctrl.md
Name: serial_port_router_ctrl

Overview:
- Controller that sequences the 1-to-4 serial output demux.
- Parses a framed bit stream on ser_in: start bit, then a port number, then a data length, then the payload.
- Drives port_sel, data_valid and data_out so the demux steers exactly the payload bits to the selected port.
- Signals frame completion with a one-cycle done pulse.

Parameters:
- PORT_W, 2, width of the port-number field; selects one of 2^PORT_W demux outputs.
- LEN_W, 4, width of the payload-length field; payload length N ranges 0..2^LEN_W-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ser_in  in  1  serial input; line idles high; sampled on every rising clk edge.
- port_sel  out  PORT_W  registered port number, driven to the demux select.
- data_out  out  1  payload bit to the demux serial input; equals ser_in while data_valid=1, else 0.
- data_valid  out  1  high while a payload bit is being forwarded.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse marking end of frame.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n=0 forces state=IDLE, port_sel=0, len_reg=0, bit_cnt=0.
  - While in reset, data_valid=0, data_out=0, busy=0, done=0.
  - Reset asserted mid-frame aborts the frame. No done pulse is produced. The next frame needs a fresh start bit.
- Frame format, all fields MSB first, one bit per clk:
  - 1 start bit, value 0.
  - PORT_W port bits.
  - LEN_W length bits.
  - N payload bits.
- States:
  - IDLE: wait for ser_in=0, then go to PORT with bit_cnt=0. ser_in=1 stays in IDLE.
  - PORT: shift ser_in into port_sel; port_sel = {port_sel[PORT_W-2:0], ser_in}. After PORT_W bits go to LEN with bit_cnt=0.
    - port_sel shows partial values while shifting. The demux ignores them because data_valid=0.
  - LEN: shift ser_in into len_reg. On the last length bit, evaluate the complete length value:
    - N=0: go to DONE.
    - N>0: go to DATA with bit_cnt=0.
  - DATA:
    - data_valid=1 and data_out=ser_in, combinationally in the same cycle.
    - bit_cnt increments each cycle.
    - When bit_cnt=N-1, go to DONE.
    - port_sel is held constant for the whole of DATA.
  - DONE: done=1 for exactly one cycle; ser_in is ignored; next state is IDLE.
- Latency:
  - First payload bit is forwarded 1+PORT_W+LEN_W cycles after the start-bit edge; 7 cycles with defaults.
  - done rises the cycle after the last payload bit.
- Back-to-back frames: the earliest next start bit is sampled in the cycle after DONE. Frames are never overlapped.
- port_sel keeps its last value in IDLE and DONE, until the next PORT state overwrites it.
- Counters: bit_cnt is sized max(PORT_W, LEN_W) bits and wraps never. The maximum count is 2^LEN_W-1, which fits.

Decomposition:
- Package serial_router_pkg holds:
  - the state enum (IDLE, PORT, LEN, DATA, DONE);
  - PORT_W and LEN_W default constants;
  - the start-bit value constant (0).
- No sub-module is needed. The demux stays a separate instance, driven by port_sel, data_out and data_valid.

Test Plan:
- Reset mid-DATA: assert rst_n=0 during the 3rd payload bit -> outputs cleared immediately; port_sel=0; no done; next frame parsed correctly.
- Idle line: ser_in=1 for 20 cycles -> busy=0, data_valid=0, done=0 throughout.
- Frame port=2, N=3, payload 1,0,1:
  - ser_in = 0,1,0,0,0,1,1,1,0,1 -> port_sel=2 from the PORT phase onward;
  - data_valid=1 for exactly 3 cycles with data_out=1,0,1;
  - done pulses 1 cycle later;
  - busy falls the cycle after done.
- Zero length, port=3, N=0: ser_in = 0,1,1,0,0,0,0 -> no data_valid cycles; done pulses the cycle after the last length bit; port_sel=3.
- Maximum length, port=1, N=15: alternating payload -> data_valid high for exactly 15 consecutive cycles; data_out mirrors ser_in each cycle.
- Back-to-back frames, port=0 N=2 then port=3 N=1: second start bit sampled in the cycle after DONE -> both frames routed correctly; two separate done pulses; port_sel changes only in the second PORT phase.
